// File: rtl/updown_counter_7seg_if.sv
// updown_counter_7seg_if: control/data bundle between the board logic and the
// multi-digit counter with multiplexed seven-segment output.
`default_nettype none

interface updown_counter_7seg_if #(
  parameter int NDIGITS = 2
);
  logic                   en;
  logic                   load;
  logic                   down;
  logic [4*NDIGITS-1:0]   data_in;
  logic [4*NDIGITS-1:0]   count;
  logic                   wrap;
  logic                   zero;
  logic [NDIGITS-1:0]     digit_sel;
  logic [7:0]             seg;

  modport master (
    output en, load, down, data_in,
    input  count, wrap, zero, digit_sel, seg
  );

  modport slave (
    input  en, load, down, data_in,
    output count, wrap, zero, digit_sel, seg
  );
endinterface

`default_nettype wire

// File: rtl/updown_counter_7seg.sv
// ============================================================================
// Module  : updown_counter_7seg
// Purpose : NDIGITS cascaded up/down counter with load, wrap pulse, zero flag
//           and time-multiplexed 7-segment output.  Define
//           UPDOWN_COUNTER_BCD_EN for decimal digits (0..9, loads clamped).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module updown_counter_7seg #(
  parameter int NDIGITS  = 2,
  parameter int SCAN_DIV = 4
) (
  input  wire logic            clk_2,
  input  wire logic            reset,
  updown_counter_7seg_if.slave bus
);

  localparam int c_W      = 4 * NDIGITS;
  localparam int c_SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [c_SCAN_W-1:0] c_SCAN_LAST = c_SCAN_W'(SCAN_DIV - 1);
`ifdef UPDOWN_COUNTER_BCD_EN
  localparam logic [3:0] c_DIGIT_MAX = 4'd9;
`else
  localparam logic [3:0] c_DIGIT_MAX = 4'd15;
`endif

  logic [c_W-1:0]      r_count;
  logic                r_wrap;
  logic [c_SCAN_W-1:0] r_scan;
  logic [NDIGITS-1:0]  r_digit_sel;
  logic [7:0]          r_seg;

  logic [c_W-1:0]      w_next;
  logic [NDIGITS:0]    w_carry;
  logic [c_W-1:0]      w_load_val;
  logic [NDIGITS-1:0]  w_sel_rot;
  logic [3:0]          w_sel_digit;
  logic [6:0]          w_seg_code;

  function automatic logic [6:0] f_seg7(input logic [3:0] d);
    case (d)
      4'h0: f_seg7 = 7'h3F;
      4'h1: f_seg7 = 7'h06;
      4'h2: f_seg7 = 7'h5B;
      4'h3: f_seg7 = 7'h4F;
      4'h4: f_seg7 = 7'h66;
      4'h5: f_seg7 = 7'h6D;
      4'h6: f_seg7 = 7'h7D;
      4'h7: f_seg7 = 7'h07;
      4'h8: f_seg7 = 7'h7F;
      4'h9: f_seg7 = 7'h6F;
      4'hA: f_seg7 = 7'h77;
      4'hB: f_seg7 = 7'h7C;
      4'hC: f_seg7 = 7'h39;
      4'hD: f_seg7 = 7'h5E;
      4'hE: f_seg7 = 7'h79;
      default: f_seg7 = 7'h71;
    endcase
  endfunction

  // Ripple cascade: a digit steps only while every lower digit rolls over;
  // carry out of the top digit is the whole-count wrap.
  always_comb begin
    logic [3:0] v_digit;
    logic       v_roll;
    w_next     = r_count;
    w_carry    = '0;
    w_carry[0] = 1'b1;
    v_digit    = '0;
    v_roll     = 1'b0;
    for (int i = 0; i < NDIGITS; i++) begin
      v_digit = r_count[4*i +: 4];
      v_roll  = bus.down ? (v_digit == 4'd0) : (v_digit == c_DIGIT_MAX);
      if (w_carry[i]) begin
        if (v_roll)
          w_next[4*i +: 4] = bus.down ? c_DIGIT_MAX : 4'd0;
        else
          w_next[4*i +: 4] = bus.down ? (v_digit - 4'd1) : (v_digit + 4'd1);
      end
      w_carry[i+1] = w_carry[i] & v_roll;
    end
  end

  always_comb begin
    w_load_val = bus.data_in;
`ifdef UPDOWN_COUNTER_BCD_EN
    for (int i = 0; i < NDIGITS; i++) begin
      if (bus.data_in[4*i +: 4] > 4'd9)
        w_load_val[4*i +: 4] = 4'd9;
    end
`endif
  end

  always_ff @(posedge clk_2) begin
    if (reset) begin
      r_count <= '0;
      r_wrap  <= 1'b0;
    end else if (bus.load) begin
      r_count <= w_load_val;
      r_wrap  <= 1'b0;
    end else if (bus.en) begin
      r_count <= w_next;
      r_wrap  <= w_carry[NDIGITS];
    end else begin
      r_wrap  <= 1'b0;
    end
  end

  generate
    if (NDIGITS == 1) begin : g_rot_single
      assign w_sel_rot = r_digit_sel;
    end else begin : g_rot_multi
      assign w_sel_rot = {r_digit_sel[NDIGITS-2:0], r_digit_sel[NDIGITS-1]};
    end
  endgenerate

  always_ff @(posedge clk_2) begin
    if (reset) begin
      r_scan      <= '0;
      r_digit_sel <= NDIGITS'(1);
    end else if (r_scan == c_SCAN_LAST) begin
      r_scan      <= '0;
      r_digit_sel <= w_sel_rot;
    end else begin
      r_scan      <= r_scan + c_SCAN_W'(1);
    end
  end

  // One-hot select makes an OR-reduction mux sufficient.
  always_comb begin
    w_sel_digit = '0;
    for (int i = 0; i < NDIGITS; i++) begin
      if (r_digit_sel[i])
        w_sel_digit = w_sel_digit | r_count[4*i +: 4];
    end
  end

  assign w_seg_code = f_seg7(w_sel_digit);

  always_ff @(posedge clk_2) begin
    if (reset)
      r_seg <= 8'h3F;
    else
      r_seg <= {r_digit_sel[0] & bus.down, w_seg_code};
  end

  assign bus.count     = r_count;
  assign bus.wrap      = r_wrap;
  assign bus.zero      = (r_count == '0);
  assign bus.digit_sel = r_digit_sel;
  assign bus.seg       = r_seg;

endmodule

`default_nettype wire

// File: tb/tb_updown_counter_7seg.sv
// tb_updown_counter_7seg: directed vector table plus scan sequence for the
// two-digit counter (hex build unless UPDOWN_COUNTER_BCD_EN is defined).
`default_nettype none

module tb_updown_counter_7seg;

  logic clk_2 = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk_2 = ~clk_2;

  updown_counter_7seg_if #(.NDIGITS(2)) bus ();

  updown_counter_7seg #(.NDIGITS(2), .SCAN_DIV(4)) dut (
    .clk_2 (clk_2),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic       rst;
    logic       ld;
    logic       en;
    logic       dn;
    logic [7:0] din;
    logic [7:0] cnt;
    logic       wrap;
    logic       zero;
  } vec_t;

  vec_t vecs[32];
  int   n_vec = 0;

  task automatic add(input logic rst, input logic ld, input logic en, input logic dn,
                     input logic [7:0] din, input logic [7:0] cnt,
                     input logic wrap, input logic zero);
    vecs[n_vec] = '{rst, ld, en, dn, din, cnt, wrap, zero};
    n_vec++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_2);
    #1;
  endtask

  function automatic logic [1:0] exp_sel(input int k);
    return ((k / 4) % 2 == 0) ? 2'b01 : 2'b10;
  endfunction

  initial begin
    logic [7:0] exp_seg;
    logic [7:0] d0_code;
    logic [7:0] scan_cnt;

    bus.en = 1'b0; bus.load = 1'b0; bus.down = 1'b0; bus.data_in = '0;

`ifdef UPDOWN_COUNTER_BCD_EN
    add(0, 1, 0, 0, 8'h99, 8'h99, 0, 0);
    add(0, 0, 1, 0, 8'h00, 8'h00, 1, 1);
    add(0, 0, 1, 0, 8'h00, 8'h01, 0, 0);
    add(0, 1, 0, 0, 8'hAB, 8'h99, 0, 0);
    add(0, 1, 0, 1, 8'h00, 8'h00, 0, 1);
    add(0, 0, 1, 1, 8'h00, 8'h99, 1, 0);
    add(0, 0, 1, 1, 8'h00, 8'h98, 0, 0);
    add(0, 1, 1, 0, 8'h5C, 8'h59, 0, 0);
    add(0, 0, 0, 0, 8'h00, 8'h59, 0, 0);
    add(0, 0, 0, 1, 8'h00, 8'h59, 0, 0);
    add(0, 1, 0, 0, 8'h09, 8'h09, 0, 0);
    add(0, 0, 1, 0, 8'h00, 8'h10, 0, 0);
    add(1, 0, 1, 0, 8'h00, 8'h00, 0, 1);
    d0_code  = 8'h6F;
    scan_cnt = 8'h39;
`else
    add(0, 1, 1, 0, 8'hFE, 8'hFE, 0, 0);
    add(0, 0, 1, 0, 8'h00, 8'hFF, 0, 0);
    add(0, 0, 1, 0, 8'h00, 8'h00, 1, 1);
    add(0, 0, 1, 0, 8'h00, 8'h01, 0, 0);
    add(0, 1, 1, 1, 8'h10, 8'h10, 0, 0);
    add(0, 0, 1, 1, 8'h00, 8'h0F, 0, 0);
    add(0, 0, 1, 1, 8'h00, 8'h0E, 0, 0);
    add(0, 1, 0, 1, 8'h00, 8'h00, 0, 1);
    add(0, 0, 1, 1, 8'h00, 8'hFF, 1, 0);
    for (int i = 0; i < 5; i++) add(0, 0, 0, (i % 2 == 1), 8'h55, 8'hFF, 0, 0);
    add(0, 0, 1, 0, 8'h00, 8'h00, 1, 1);
    add(0, 1, 0, 0, 8'hFF, 8'hFF, 0, 0);
    add(0, 0, 1, 0, 8'h00, 8'h00, 1, 1);
    add(0, 0, 1, 0, 8'h00, 8'h01, 0, 0);
    add(0, 0, 1, 0, 8'h00, 8'h02, 0, 0);
    add(1, 0, 1, 0, 8'h00, 8'h00, 0, 1);
    d0_code  = 8'h77;
    scan_cnt = 8'h3A;
`endif

    // Reset held for two cycles.
    reset = 1'b1;
    tick();
    tick();
    check("reset_count", 32'(bus.count), 32'h00);
    check("reset_zero", 32'(bus.zero), 32'h1);
    check("reset_wrap", 32'(bus.wrap), 32'h0);
    check("reset_digit_sel", 32'(bus.digit_sel), 32'h1);
    check("reset_seg", 32'(bus.seg), 32'h3F);
    reset = 1'b0;

    for (int i = 0; i < n_vec; i++) begin
      reset        = vecs[i].rst;
      bus.load     = vecs[i].ld;
      bus.en       = vecs[i].en;
      bus.down     = vecs[i].dn;
      bus.data_in  = vecs[i].din;
      tick();
      check($sformatf("vec%0d_count", i), 32'(bus.count), 32'(vecs[i].cnt));
      check($sformatf("vec%0d_wrap", i), 32'(bus.wrap), 32'(vecs[i].wrap));
      check($sformatf("vec%0d_zero", i), 32'(bus.zero), 32'(vecs[i].zero));
    end

    // Scan sequence: reset at E0, load at E1, then free-running with down
    // raised from E9 onward so dp appears on digit 0 only.
    reset = 1'b1; bus.load = 1'b0; bus.en = 1'b0; bus.down = 1'b0;
    tick();
    reset = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      bus.load    = (k == 1);
      bus.data_in = 8'h3A;
      bus.en      = 1'b0;
      bus.down    = (k >= 9);
      tick();
      if (k == 1)
        exp_seg = 8'h3F;
      else if (exp_sel(k - 1) == 2'b01)
        exp_seg = {bus.down, d0_code[6:0]};
      else
        exp_seg = 8'h4F;
      check($sformatf("scan%0d_digit_sel", k), 32'(bus.digit_sel), 32'(exp_sel(k)));
      check($sformatf("scan%0d_seg", k), 32'(bus.seg), 32'(exp_seg));
      if (k == 1 || k == 20)
        check($sformatf("scan%0d_count", k), 32'(bus.count), 32'(scan_cnt));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
